// File: rtl/lfsr_rng_gen.sv
// lfsr_rng_gen: parameterised Fibonacci XNOR LFSR random-word generator.
// Each output word is taken after SHIFTS LFSR shifts. A runtime seed load and
// an enable are provided, and output uses a valid/ready handshake with back-pressure.
// Optional build macro RNG_SEED_GUARD_EN: an all-ones seed is replaced by
// DEFAULT_SEED and seed_err pulses for one cycle. Without the macro, seed_err is tied 0.
module lfsr_rng_gen #(
    parameter int                WIDTH        = 10,
    parameter logic [WIDTH-1:0]  TAPS         = 10'h246,
    parameter logic [WIDTH-1:0]  DEFAULT_SEED = 10'h3E7,
    parameter int                SHIFTS       = WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] rnd,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             seed_err
);

    localparam logic [7:0] LAST = 8'(SHIFTS - 1);

    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] seed_eff;
    logic [7:0]       count;
    logic             fb;
    logic             last;
    logic             stall;
    logic             advance;
    logic             produce;

    // XNOR feedback makes all-ones the lock-up state, so all-zeros is legal.
    assign fb        = ~^(lfsr & TAPS);
    assign lfsr_next = {lfsr[WIDTH-2:0], fb};

    // A finished word may only leave the LFSR once the previous word is gone.
    assign last    = (count == LAST);
    assign stall   = last && rnd_valid && !rnd_ready;
    assign advance = !seed_load && enable && !stall;
    assign produce = advance && last;

`ifdef RNG_SEED_GUARD_EN
    logic seed_bad;

    assign seed_bad = &seed_in;
    assign seed_eff = seed_bad ? DEFAULT_SEED : seed_in;

    // Flag a rejected all-ones seed on the cycle after the load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            seed_err <= 1'b0;
        else
            seed_err <= seed_load && seed_bad;
    end
`else
    assign seed_eff = seed_in;
    assign seed_err = 1'b0;
`endif

    // LFSR state and shift counter. A seed load takes priority over enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr  <= DEFAULT_SEED;
            count <= 8'd0;
        end else if (seed_load) begin
            lfsr  <= seed_eff;
            count <= 8'd0;
        end else if (advance) begin
            lfsr  <= lfsr_next;
            count <= last ? 8'd0 : count + 8'd1;
        end
    end

    // Output word and valid flag. A new word may replace one being taken in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rnd       <= '0;
            rnd_valid <= 1'b0;
        end else if (seed_load) begin
            rnd_valid <= 1'b0;
        end else if (produce) begin
            rnd       <= lfsr_next;
            rnd_valid <= 1'b1;
        end else if (rnd_valid && rnd_ready) begin
            rnd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_rng_gen.sv
// Bench for lfsr_rng_gen. It drives two instances with default width, taps and
// seed: one with SHIFTS=10 and one with SHIFTS=1. Directed steps are followed
// by a randomised run. Both instances are compared on every cycle against a
// sequence model in the bench.
module tb_lfsr_rng_gen;

`ifdef RNG_SEED_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       seed_load;
    logic [9:0] seed_in;
    logic       rdy_a, rdy_b;
    logic [9:0] rnd_a, rnd_b;
    logic       vld_a, vld_b;
    logic       err_a, err_b;

    int vecs  = 0;
    int fails = 0;

    // model state, index 0 = SHIFTS 10, index 1 = SHIFTS 1
    logic [9:0] m_lfsr [2];
    logic [9:0] m_rnd  [2];
    int         m_cnt  [2];
    logic       m_vld  [2];
    logic       m_err  [2];
    int         shf    [2] = '{10, 1};

    always #5 clock = ~clock;

    lfsr_rng_gen #(.SHIFTS(10)) dut_a (
        .clock(clock), .reset_n(reset_n), .enable(enable), .seed_load(seed_load),
        .seed_in(seed_in), .rnd(rnd_a), .rnd_valid(vld_a), .rnd_ready(rdy_a),
        .seed_err(err_a)
    );

    lfsr_rng_gen #(.SHIFTS(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .enable(enable), .seed_load(seed_load),
        .seed_in(seed_in), .rnd(rnd_b), .rnd_valid(vld_b), .rnd_ready(rdy_b),
        .seed_err(err_b)
    );

    // Next state: shift left, and shift in 1 when the tapped bits (9,6,2,1)
    // hold an even number of ones.
    function automatic logic [9:0] next_state(input logic [9:0] s);
        int ones;
        ones = $countones(s & 10'h246);
        return {s[8:0], (ones % 2 == 0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_lfsr[k] = 10'h3E7;
            m_rnd[k]  = 10'h000;
            m_cnt[k]  = 0;
            m_vld[k]  = 1'b0;
            m_err[k]  = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic       rdy;
            logic       last;
            logic       stall;
            logic [9:0] nx;
            rdy   = (k == 0) ? rdy_a : rdy_b;
            last  = (m_cnt[k] == shf[k] - 1);
            stall = last && m_vld[k] && !rdy;
            nx    = next_state(m_lfsr[k]);
            m_err[k] = 1'b0;
            if (seed_load) begin
                m_err[k]  = GUARD && (seed_in == 10'h3FF);
                m_lfsr[k] = m_err[k] ? 10'h3E7 : seed_in;
                m_cnt[k]  = 0;
                m_vld[k]  = 1'b0;
            end else begin
                if (m_vld[k] && rdy) m_vld[k] = 1'b0;
                if (enable && !stall) begin
                    m_lfsr[k] = nx;
                    if (last) begin
                        m_cnt[k] = 0;
                        m_rnd[k] = nx;
                        m_vld[k] = 1'b1;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("rnd_a", rnd_a, m_rnd[0]);
        chk("vld_a", vld_a, m_vld[0]);
        chk("err_a", err_a, m_err[0]);
        chk("rnd_b", rnd_b, m_rnd[1]);
        chk("vld_b", vld_b, m_vld[1]);
        chk("err_b", err_b, m_err[1]);
    endtask

    // one clock: model sees the same pre-edge inputs, DUT sampled 1 after edge
    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; seed_load = 1'b0; seed_in = 10'h000;
        rdy_a = 1'b0; rdy_b = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        chk("reset_rnd_a", rnd_a, 10'h000);
        chk("reset_vld_a", vld_a, 1'b0);

        // first word after reset release
        reset_n = 1'b1; enable = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (i < 10)  chk("pre_first_vld_a", vld_a, 1'b0);
            if (i == 10) chk("first_word_a", rnd_a, 10'h307);
            if (i == 10) chk("first_vld_a", vld_a, 1'b1);
            if (i == 1)  chk("b_word1", rnd_b, 10'h3CF);
            if (i == 2)  chk("b_word2", rnd_b, 10'h39F);
            if (i == 3)  chk("b_word3", rnd_b, 10'h33E);
        end

        // seed load in the middle of a word (count=4) while a word is pending
        rdy_a = 1'b0;
        repeat (4) cyc();
        chk("pending_vld_a", vld_a, 1'b1);
        seed_load = 1'b1; seed_in = 10'h3E7;
        cyc();
        seed_load = 1'b0;
        chk("load_clr_vld_a", vld_a, 1'b0);
        chk("load_clr_vld_b", vld_b, 1'b0);
        rdy_a = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            if (i == 2) rdy_b = 1'b0;
            if (i == 7) rdy_b = 1'b1;
            cyc();
            if (i < 10)  chk("reload_vld_a", vld_a, 1'b0);
            if (i == 10) chk("reload_word_a", rnd_a, 10'h307);
            if (i <= 6)  chk("bp_hold_b", rnd_b, 10'h3CF);
            if (i <= 6)  chk("bp_vld_b", vld_b, 1'b1);
            if (i == 7)  chk("bp_next_b", rnd_b, 10'h39F);
        end

        // all-ones seed, handled according to the guard build option
        seed_load = 1'b1; seed_in = 10'h3FF;
        cyc();
        seed_load = 1'b0;
        chk("seed_err_pulse", err_a, GUARD);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (i == 1)  chk("seed_err_end", err_a, 1'b0);
            if (i == 10) chk("ones_first_word", rnd_a, GUARD ? 10'h307 : 10'h3FF);
        end
        repeat (10) cyc();
        chk("ones_later_word", rnd_a, GUARD ? m_rnd[0] : 10'h3FF);

        // stall A, then apply an asynchronous reset between edges
        rdy_a = 1'b0;
        seed_load = 1'b1; seed_in = 10'h3E7;
        cyc();
        seed_load = 1'b0;
        repeat (20) cyc();
        chk("stall_hold_a", rnd_a, 10'h307);
        chk("stall_vld_a", vld_a, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_rnd_a", rnd_a, 10'h000);
        chk("async_rst_vld_a", vld_a, 1'b0);
        chk("async_rst_vld_b", vld_b, 1'b0);
        model_reset();
        #1 reset_n = 1'b1;
        rdy_a = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (i < 10)  chk("restart_vld_a", vld_a, 1'b0);
            if (i == 10) chk("restart_word_a", rnd_a, 10'h307);
        end

        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            enable    = ($urandom_range(0, 3) != 0);
            seed_load = ($urandom_range(0, 31) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom);
            rdy_a     = ($urandom_range(0, 2) != 0);
            rdy_b     = ($urandom_range(0, 1) != 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
